// File: rtl/sparse_polymult_core.sv
// Sparse GF(2) polynomial multiplier mod (x^pN - 1) for the CW305 block interface.
// One key slot per cycle; dummy slots feed a shadow accumulator so timing is key-independent.
module sparse_polymult_core #(
    parameter int pN         = 128,
    parameter int pIDX_WIDTH = 7,
    parameter int pSLOTS     = 16,
    parameter int pKEY_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_i,
    input  logic [pKEY_WIDTH-1:0] key_i,
    input  logic [pN-1:0]         data_i,
    output logic [pN-1:0]         data_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  idle_o,
    output logic                  done_o
);

    localparam int SLOT_W   = pIDX_WIDTH + 1;
    localparam int KEY_USED = pSLOTS * SLOT_W;
    localparam int CNT_W    = (pSLOTS > 1) ? $clog2(pSLOTS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(pSLOTS - 1);

    typedef enum logic {S_IDLE, S_MULT} state_t;

    state_t                          r_state;
    logic [KEY_USED-1:0]             r_key;
    logic [pN-1:0]                   r_data;
    logic [CNT_W-1:0]                r_cnt;
    logic [pN-1:0]                   r_acc;
    (* keep = "true" *) logic [pN-1:0] r_dummy_acc;
    logic [pN-1:0]                   r_data_out;
    logic                            r_done;
    logic                            r_busy;

    state_t                          w_nxt_state;
    logic [KEY_USED-1:0]             w_nxt_key;
    logic [pN-1:0]                   w_nxt_data;
    logic [CNT_W-1:0]                w_nxt_cnt;
    logic [pN-1:0]                   w_nxt_acc;
    logic [pN-1:0]                   w_nxt_dummy_acc;
    logic [pN-1:0]                   w_nxt_data_out;
    logic                            w_nxt_done;
    logic                            w_nxt_busy;

    logic [pSLOTS-1:0][SLOT_W-1:0]   w_slots;
    logic [SLOT_W-1:0]               w_slot;
    logic [pIDX_WIDTH-1:0]           w_idx;
    logic [31:0]                     w_rshift;
    logic [pN-1:0]                   w_rot;

    assign w_slots  = r_key;
    assign w_slot   = w_slots[r_cnt];
    assign w_idx    = w_slot[pIDX_WIDTH-1:0];
    // Right shift by pN when idx is 0 yields zero, so the OR degenerates to the plain operand.
    assign w_rshift = 32'(pN) - 32'(w_idx);
    assign w_rot    = (r_data << w_idx) | (r_data >> w_rshift);

    // NOTE: every next-state variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_key       = r_key;
        w_nxt_data      = r_data;
        w_nxt_cnt       = r_cnt;
        w_nxt_acc       = r_acc;
        w_nxt_dummy_acc = r_dummy_acc;
        w_nxt_data_out  = r_data_out;
        w_nxt_done      = r_done;
        w_nxt_busy      = r_busy;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nxt_key       = key_i[KEY_USED-1:0];
                    w_nxt_data      = data_i;
                    w_nxt_acc       = '0;
                    w_nxt_dummy_acc = '0;
                    w_nxt_cnt       = '0;
                    w_nxt_done      = 1'b0;
                    w_nxt_busy      = 1'b1;
                    w_nxt_state     = S_MULT;
                end
            end
            S_MULT: begin
                if (w_slot[SLOT_W-1]) begin
                    w_nxt_acc = r_acc ^ w_rot;
                end else begin
                    w_nxt_dummy_acc = r_dummy_acc ^ w_rot;
                end
                w_nxt_cnt = r_cnt + 1'b1;
                if (r_cnt == LAST_SLOT) begin
                    w_nxt_data_out = w_nxt_acc;
                    w_nxt_done     = 1'b1;
                    w_nxt_busy     = 1'b0;
                    w_nxt_state    = S_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_dummy_acc <= '0;
            r_data_out  <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_key       <= w_nxt_key;
            r_data      <= w_nxt_data;
            r_cnt       <= w_nxt_cnt;
            r_acc       <= w_nxt_acc;
            r_dummy_acc <= w_nxt_dummy_acc;
            r_data_out  <= w_nxt_data_out;
            r_done      <= w_nxt_done;
            r_busy      <= w_nxt_busy;
        end
    end

    assign data_o  = r_data_out;
    assign done_o  = r_done;
    assign busy_o  = r_busy;
    assign ready_o = ~r_busy;
    assign idle_o  = ~r_busy;

endmodule
